// File: rtl/gpr_file_mp.sv
// Multi-read-port GPR file for the pipelined MIPS core: main WB write port, jal link port,
// optional same-cycle write-through bypass and a post-reset sequential sweep-clear.
module gpr_file_mp #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_RD   = 2,
    parameter int LINK_REG = 31,
    parameter int BYPASS   = 1
) (
    input  logic                     Clk,
    input  logic                     Reset_n,
    input  logic [NUM_RD*ADDR_W-1:0] RAddr,
    output logic [NUM_RD*DATA_W-1:0] RData,
    input  logic                     WE,
    input  logic [ADDR_W-1:0]        WA,
    input  logic [DATA_W-1:0]        WData,
    input  logic                     LinkWE,
    input  logic [DATA_W-1:0]        LinkData,
    output logic                     Busy,
    output logic                     Conflict
);

    localparam int DEPTH = 2**ADDR_W;
    localparam logic [ADDR_W-1:0] LINK_A = ADDR_W'(LINK_REG);
    localparam logic [ADDR_W-1:0] LAST_A = ADDR_W'(DEPTH-1);

    typedef enum logic {S_CLEAR, S_RUN} state_t;

    state_t              r_state;
    logic [ADDR_W-1:0]   r_clrPtr;
    logic                r_conflict;
    logic [DATA_W-1:0]   r_mem [DEPTH];

    logic w_we;
    logic w_linkWe;
    logic w_linkHit;
    logic w_mainHit;
    logic w_collide;

    // Write enables are only honoured in RUN; an X/Z enable falls through to 0.
    always_comb begin
        w_we     = 1'b0;
        w_linkWe = 1'b0;
        if (r_state == S_RUN) begin
            if (WE)
                w_we = 1'b1;
            if (LinkWE)
                w_linkWe = 1'b1;
        end
    end

    assign w_collide = w_we && w_linkWe && (WA == LINK_A);
    assign w_linkHit = w_linkWe && (LINK_A != '0);
    assign w_mainHit = w_we && (WA != '0) && !(w_linkHit && (WA == LINK_A));

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            r_state    <= S_CLEAR;
            r_clrPtr   <= '0;
            r_conflict <= 1'b0;
        end else begin
            case (r_state)
                S_CLEAR: begin
                    r_clrPtr <= r_clrPtr + ADDR_W'(1);
                    if (r_clrPtr == LAST_A)
                        r_state <= S_RUN;
                end
                S_RUN: begin
                    if (w_collide)
                        r_conflict <= 1'b1;
                end
                default: r_state <= S_CLEAR;
            endcase
        end
    end

    // Storage has no reset of its own so it can map to distributed RAM; the sweep zeroes it.
    always_ff @(posedge Clk) begin
        if (Reset_n) begin
            if (r_state == S_CLEAR) begin
                r_mem[r_clrPtr] <= '0;
            end else begin
                if (w_mainHit)
                    r_mem[WA] <= WData;
                if (w_linkHit)
                    r_mem[LINK_A] <= LinkData;
            end
        end
    end

    assign Busy     = (r_state == S_CLEAR);
    assign Conflict = r_conflict;

    genvar k;
    generate
        for (k = 0; k < NUM_RD; k++) begin : g_rd
            logic [ADDR_W-1:0] w_ra;
            logic [DATA_W-1:0] w_rd;

            assign w_ra = RAddr[k*ADDR_W +: ADDR_W];

            // Link data outranks main write data, matching the collision rule at the write edge.
            always_comb begin
                w_rd = '0;
                if ((r_state == S_RUN) && (w_ra != '0)) begin
                    if ((BYPASS != 0) && w_linkWe && (w_ra == LINK_A))
                        w_rd = LinkData;
                    else if ((BYPASS != 0) && w_we && (w_ra == WA))
                        w_rd = WData;
                    else
                        w_rd = r_mem[w_ra];
                end
            end

            assign RData[k*DATA_W +: DATA_W] = w_rd;
        end
    endgenerate

endmodule
